// File: rtl/sdram_aref_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n} and
// default timing wait counts used by the init, refresh and arbiter stages.
package sdram_aref_pkg;

    typedef enum logic [3:0] {
        NOP_CMD       = 4'b1000,
        PRE_CHARG_CMD = 4'b0010,
        AUTO_REF_CMD  = 4'b0001,
        MOD_REG_CMD   = 4'b0000
    } sdram_cmd_e;

    localparam int unsigned T_RP_CNT  = 2;
    localparam int unsigned T_RFC_CNT = 7;

endpackage

// File: rtl/sdram_wait_cnt.sv
// Wait-state cycle counter: counts from 0 while enabled, flags the terminal
// count and clears itself on that cycle or whenever disabled.
module sdram_wait_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] last,
    output logic       done
);

    logic [2:0] cnt_clk_q, cnt_clk_d;

    always_comb begin
        done      = en && (cnt_clk_q == last);
        cnt_clk_d = (en && !done) ? cnt_clk_q + 3'd1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_clk_q <= '0;
        else        cnt_clk_q <= cnt_clk_d;
    end

endmodule

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh controller: requests a refresh slot every interval and,
// once granted, issues precharge-all followed by AREF_NUM auto-refreshes.
module sdram_aref
    import sdram_aref_pkg::*;
#(
    parameter int unsigned CNT_REF_MAX = 749,
    parameter int unsigned CNT_TRP     = T_RP_CNT,
    parameter int unsigned CNT_TRFC    = T_RFC_CNT,
    parameter int unsigned AREF_NUM    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_bank_addr,
    output logic [12:0] aref_addr,
    output logic        aref_end
);

    localparam int unsigned REF_W  = $clog2(CNT_REF_MAX + 1);
    localparam int unsigned AREF_W = $clog2(AREF_NUM + 1);

    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        PRE_CHARG = 6'b000010,
        WAIT_TRP  = 6'b000100,
        AUTO_REF  = 6'b001000,
        WAIT_TRFC = 6'b010000,
        AREF_END  = 6'b100000
    } state_e;

    state_e            state_q, state_d;
    sdram_cmd_e        aref_cmd_q, aref_cmd_d;
    logic [REF_W-1:0]  cnt_ref_q, cnt_ref_d;
    logic [AREF_W-1:0] cnt_aref_q, cnt_aref_d;
    logic              aref_req_q, aref_req_d;
    logic              ref_wrap, accept, in_wait, wait_done;
    logic [2:0]        wait_last;

    sdram_wait_cnt u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_wait),
        .last  (wait_last),
        .done  (wait_done)
    );

    always_comb begin
        in_wait   = init_end && (state_q == WAIT_TRP || state_q == WAIT_TRFC);
        wait_last = (state_q == WAIT_TRP) ? 3'(CNT_TRP) : 3'(CNT_TRFC);
        ref_wrap  = init_end && (cnt_ref_q == REF_W'(CNT_REF_MAX));
        accept    = (state_q == IDLE) && aref_req_q && aref_en;
        cnt_ref_d = (!init_end || ref_wrap) ? '0 : cnt_ref_q + REF_W'(1);

        // A wrap coinciding with acceptance wins so that interval is not lost.
        aref_req_d = aref_req_q;
        if (!init_end)     aref_req_d = 1'b0;
        else if (ref_wrap) aref_req_d = 1'b1;
        else if (accept)   aref_req_d = 1'b0;

        state_d    = state_q;
        cnt_aref_d = cnt_aref_q;
        unique case (state_q)
            IDLE: begin
                cnt_aref_d = '0;
                if (accept) state_d = PRE_CHARG;
            end
            PRE_CHARG: state_d = WAIT_TRP;
            WAIT_TRP:  if (wait_done) state_d = AUTO_REF;
            AUTO_REF:  state_d = WAIT_TRFC;
            WAIT_TRFC: begin
                if (wait_done) begin
                    cnt_aref_d = cnt_aref_q + AREF_W'(1);
                    state_d    = (cnt_aref_q == AREF_W'(AREF_NUM - 1)) ? AREF_END : AUTO_REF;
                end
            end
            AREF_END:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (!init_end) state_d = IDLE;

        aref_cmd_d = NOP_CMD;
        if (init_end) begin
            if (state_q == PRE_CHARG)     aref_cmd_d = PRE_CHARG_CMD;
            else if (state_q == AUTO_REF) aref_cmd_d = AUTO_REF_CMD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_ref_q  <= '0;
            cnt_aref_q <= '0;
            aref_req_q <= 1'b0;
            aref_cmd_q <= NOP_CMD;
        end else begin
            state_q    <= state_d;
            cnt_ref_q  <= cnt_ref_d;
            cnt_aref_q <= cnt_aref_d;
            aref_req_q <= aref_req_d;
            aref_cmd_q <= aref_cmd_d;
        end
    end

    assign aref_req       = aref_req_q;
    assign aref_cmd       = aref_cmd_q;
    assign aref_end       = (state_q == AREF_END);
    assign aref_bank_addr = 2'b11;
    assign aref_addr      = 13'h1fff;

endmodule

// File: tb/tb_sdram_aref.sv
// Self-checking bench for sdram_aref: a cycle-offset reference model of the
// refresh timeline, directed scenarios and a randomized grant/init/reset phase.
module tb_sdram_aref;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_end = 1'b0;
    logic        aref_en = 1'b0;
    logic        aref_req;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_bank_addr;
    logic [12:0] aref_addr;
    logic        aref_end;

    always #5 clk = ~clk;

    sdram_aref #(
        .CNT_REF_MAX (749),
        .CNT_TRP     (2),
        .CNT_TRFC    (7),
        .AREF_NUM    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_end       (init_end),
        .aref_en        (aref_en),
        .aref_req       (aref_req),
        .aref_cmd       (aref_cmd),
        .aref_bank_addr (aref_bank_addr),
        .aref_addr      (aref_addr),
        .aref_end       (aref_end)
    );

    localparam int INTERVAL = 750;
    localparam int SEQ_LEN  = 24;

    int checks = 0;
    int failures = 0;

    // Model: interval position, pending request, and cycles since the grant
    // edge (-1 when idle). Commands follow fixed offsets from the grant.
    int m_ref = 0;
    bit m_req = 1'b0;
    int m_off = -1;
    int n_end_obs = 0;
    int n_end_exp = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_cmd(input int off);
        if (off == 2)                return 4'b0010;
        if (off == 6 || off == 15)   return 4'b0001;
        return 4'b1000;
    endfunction

    task automatic model_update();
        bit wrap, acc;
        if (!rst_n) begin
            m_ref = 0;
            m_req = 1'b0;
            m_off = -1;
        end else begin
            wrap = init_end && (m_ref == INTERVAL - 1);
            acc  = (m_off < 0) && m_req && aref_en;
            if (!init_end)  m_req = 1'b0;
            else if (wrap)  m_req = 1'b1;
            else if (acc)   m_req = 1'b0;
            m_ref = !init_end ? 0 : (m_ref + 1) % INTERVAL;
            if (!init_end)       m_off = -1;
            else if (acc)        m_off = 1;
            else if (m_off >= 0) m_off = (m_off + 1 == SEQ_LEN) ? -1 : m_off + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        if (m_off == 23) n_end_exp++;
        if (aref_end === 1'b1) n_end_obs++;
        chk("aref_req", aref_req, m_req);
        chk("aref_cmd", aref_cmd, exp_cmd(m_off));
        chk("aref_end", aref_end, (m_off == 23));
        chk("bank_addr", aref_bank_addr, 2'b11);
        chk("addr", aref_addr, 13'h1fff);
    endtask

    task automatic wait_idle_req(input int limit);
        int n = 0;
        aref_en = 1'b0;
        while (!(m_req && m_off < 0 && aref_req === 1'b1) && n < limit) begin
            step();
            n++;
        end
        chk("wait_req_timeout", (n < limit), 1'b1);
    endtask

    task automatic grant_and_watch();
        int pre_at = -1, ref1_at = -1, ref2_at = -1, end_at = -1;
        aref_en = 1'b1;
        step();
        aref_en = 1'b0;
        for (int k = 2; k <= 30; k++) begin
            step();
            if (aref_cmd === 4'b0010 && pre_at < 0) pre_at = k;
            if (aref_cmd === 4'b0001) begin
                if (ref1_at < 0) ref1_at = k;
                else if (ref2_at < 0) ref2_at = k;
            end
            if (aref_end === 1'b1 && end_at < 0) end_at = k;
        end
        chk("lat_pre", pre_at, 2);
        chk("lat_aref1", ref1_at, 6);
        chk("lat_aref2", ref2_at, 15);
        chk("lat_end", end_at, 23);
    endtask

    initial begin
        int n, ends_before;

        // Reset with init held low, then a long uninitialised stretch.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rst_req", aref_req, 1'b0);
        chk("rst_cmd", aref_cmd, 4'b1000);
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            aref_en = ($urandom_range(0, 3) == 0);
            step();
        end
        aref_en = 1'b0;

        // First request latency after init completes, then unserviced repeats.
        init_end = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (aref_req !== 1'b1 && n < 900);
        chk("req_first_rise", n, INTERVAL);
        for (int i = 0; i < 2 * INTERVAL + 5; i++) step();
        chk("req_overdue_hold", aref_req, 1'b1);

        // Full sequence latency.
        grant_and_watch();

        // Grant held while no request is pending.
        while (m_ref > 600) step();
        aref_en = 1'b1;
        for (int i = 0; i < 100; i++) step();
        aref_en = 1'b0;

        // Grant on the wrap cycle keeps the request; second grant runs fully.
        n = 0;
        while (!(m_ref == INTERVAL - 1 && m_req && m_off < 0) && n < 2000) begin
            step();
            n++;
        end
        chk("wrap_align_timeout", (n < 2000), 1'b1);
        aref_en = 1'b1;
        step();
        aref_en = 1'b0;
        chk("req_hold_on_wrap", aref_req, 1'b1);
        for (int i = 0; i < SEQ_LEN; i++) step();
        grant_and_watch();

        // Randomized grants, init drops and resets.
        for (int i = 0; i < 8000; i++) begin
            aref_en = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) init_end = ~init_end;
            else if (!init_end && $urandom_range(0, 29) == 0) init_end = 1'b1;
            rst_n = ($urandom_range(0, 1999) != 0);
            step();
        end
        rst_n = 1'b1;
        init_end = 1'b1;
        aref_en = 1'b0;

        // Reset at N+10 aborts the sequence.
        wait_idle_req(1600);
        aref_en = 1'b1;
        step();
        aref_en = 1'b0;
        for (int i = 0; i < 9; i++) step();
        ends_before = n_end_obs;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_abort_req", aref_req, 1'b0);
        for (int i = 0; i < 30; i++) step();
        chk("rst_abort_no_end", n_end_obs - ends_before, 0);

        // init_end falling mid-sequence aborts it.
        wait_idle_req(1600);
        aref_en = 1'b1;
        step();
        aref_en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        ends_before = n_end_obs;
        init_end = 1'b0;
        step();
        chk("init_drop_req", aref_req, 1'b0);
        chk("init_drop_cmd", aref_cmd, 4'b1000);
        for (int i = 0; i < 30; i++) step();
        chk("init_drop_no_end", n_end_obs - ends_before, 0);

        chk("end_pulse_total", n_end_obs, n_end_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
